// File: rtl/stream_hub_rr_if.sv
// rtl/stream_hub_rr_if.sv - producer/consumer stream and exception bundle for stream_hub_rr
interface stream_hub_rr_if #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int CH_BITS = 2
);
  logic [N*W-1:0]     input_data;
  logic [N-1:0]       input_stb;
  logic [N-1:0]       input_ack;
  logic [W-1:0]       output_data;
  logic [CH_BITS-1:0] output_channel;
  logic               output_stb;
  logic               output_ack;
  logic [N-1:0]       exception_in;
  logic               exception;

  // Hub side: receives producer words and drives the merged consumer stream.
  modport slave (
    input  input_data, input_stb, output_ack, exception_in,
    output input_ack, output_data, output_channel, output_stb, exception
  );

  // Environment side: producers, consumer and exception sources.
  modport master (
    output input_data, input_stb, output_ack, exception_in,
    input  input_ack, output_data, output_channel, output_stb, exception
  );
endinterface

// File: rtl/stream_hub_rr.sv
// rtl/stream_hub_rr.sv - N-to-1 round-robin stream concentrator with channel tag and sticky exception
// Optional output stall timeout enabled by defining STREAM_HUB_RR_TIMEOUT_EN.
module stream_hub_rr #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int CH_BITS = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  stream_hub_rr_if.slave bus
);
  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, nxt_state;
  logic [CH_BITS-1:0] last_grant, nxt_last_grant;
  logic [CH_BITS-1:0] cand;
  logic               found;
  logic [N-1:0]       nxt_ack;
  logic [W-1:0]       nxt_data;
  logic [CH_BITS-1:0] nxt_channel;
  logic               nxt_stb;
  logic               nxt_exception;

`ifdef STREAM_HUB_RR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] stall_cnt, nxt_stall_cnt;
  logic [CNT_W-1:0] stall_inc;
  assign stall_inc = stall_cnt + 1'b1;
`endif

  always_comb begin
    nxt_state      = state;
    nxt_last_grant = last_grant;
    nxt_ack        = '0;
    nxt_data       = bus.output_data;
    nxt_channel    = bus.output_channel;
    nxt_stb        = bus.output_stb;
    nxt_exception  = bus.exception | (|bus.exception_in);
    cand           = '0;
    found          = 1'b0;
`ifdef STREAM_HUB_RR_TIMEOUT_EN
    nxt_stall_cnt  = stall_cnt;
`endif
    case (state)
      IDLE: begin
        // Search starts just after the last winner, so every channel waits at most N grants.
        for (int i = 1; i <= N; i++) begin
          cand = CH_BITS'((int'(last_grant) + i) % N);
          if (!found && bus.input_stb[cand]) begin
            found          = 1'b1;
            nxt_ack[cand]  = 1'b1;
            nxt_data       = bus.input_data[cand*W +: W];
            nxt_channel    = cand;
            nxt_last_grant = cand;
            nxt_stb        = 1'b1;
            nxt_state      = SEND;
`ifdef STREAM_HUB_RR_TIMEOUT_EN
            nxt_stall_cnt  = '0;
`endif
          end
        end
      end
      SEND: begin
        if (bus.output_stb && bus.output_ack) begin
          nxt_stb   = 1'b0;
          nxt_state = IDLE;
        end
`ifdef STREAM_HUB_RR_TIMEOUT_EN
        // A consumer that never accepts would otherwise starve every producer.
        else if (stall_inc == CNT_W'(TIMEOUT)) begin
          nxt_stb       = 1'b0;
          nxt_state     = IDLE;
          nxt_exception = 1'b1;
        end else begin
          nxt_stall_cnt = stall_inc;
        end
`endif
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      last_grant         <= CH_BITS'(N - 1);
      bus.input_ack      <= '0;
      bus.output_data    <= '0;
      bus.output_channel <= '0;
      bus.output_stb     <= 1'b0;
      bus.exception      <= 1'b0;
`ifdef STREAM_HUB_RR_TIMEOUT_EN
      stall_cnt          <= '0;
`endif
    end else begin
      state              <= nxt_state;
      last_grant         <= nxt_last_grant;
      bus.input_ack      <= nxt_ack;
      bus.output_data    <= nxt_data;
      bus.output_channel <= nxt_channel;
      bus.output_stb     <= nxt_stb;
      bus.exception      <= nxt_exception;
`ifdef STREAM_HUB_RR_TIMEOUT_EN
      stall_cnt          <= nxt_stall_cnt;
`endif
    end
  end
endmodule

// File: tb/tb_stream_hub_rr.sv
// tb/tb_stream_hub_rr.sv - directed self-checking bench for stream_hub_rr
module tb_stream_hub_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  stream_hub_rr_if #(.N(4), .W(32), .CH_BITS(2)) bus ();

  stream_hub_rr #(.N(4), .W(32), .CH_BITS(2), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.input_stb    = '0;
    bus.output_ack   = 1'b0;
    bus.exception_in = '0;
    bus.input_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.input_stb    = 4'b1111;
    bus.output_ack   = 1'b0;
    bus.exception_in = '0;
    bus.input_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    step();
    step();
    total_cnt++; if (bus.input_ack !== 4'b0000) $display("FAIL rst_input_ack got %b want 0000", bus.input_ack); else pass_cnt++;
    total_cnt++; if (bus.output_stb !== 1'b0) $display("FAIL rst_output_stb got %b want 0", bus.output_stb); else pass_cnt++;
    total_cnt++; if (bus.output_data !== 32'h0) $display("FAIL rst_output_data got %h want 0", bus.output_data); else pass_cnt++;
    total_cnt++; if (bus.output_channel !== 2'd0) $display("FAIL rst_output_channel got %0d want 0", bus.output_channel); else pass_cnt++;
    total_cnt++; if (bus.exception !== 1'b0) $display("FAIL rst_exception got %b want 0", bus.exception); else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++; if (bus.input_ack !== 4'b0001) $display("FAIL first_ack got %b want 0001", bus.input_ack); else pass_cnt++;
    total_cnt++; if (bus.output_channel !== 2'd0) $display("FAIL first_channel got %0d want 0", bus.output_channel); else pass_cnt++;
    total_cnt++; if (bus.output_data !== 32'hA0) $display("FAIL first_data got %h want a0", bus.output_data); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_data;
    logic [1:0]  exp_ch;
    logic [3:0]  exp_ack;
    do_reset();
    bus.input_stb  = 4'b1111;
    bus.output_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_ch   = 2'(k % 4);
      exp_data = 32'hA0 + 32'(k % 4);
      exp_ack  = 4'b0001 << (k % 4);
      step();
      total_cnt++; if (bus.output_stb !== 1'b1) $display("FAIL rr_stb k=%0d got %b want 1", k, bus.output_stb); else pass_cnt++;
      total_cnt++; if (bus.output_data !== exp_data) $display("FAIL rr_data k=%0d got %h want %h", k, bus.output_data, exp_data); else pass_cnt++;
      total_cnt++; if (bus.output_channel !== exp_ch) $display("FAIL rr_channel k=%0d got %0d want %0d", k, bus.output_channel, exp_ch); else pass_cnt++;
      total_cnt++; if (bus.input_ack !== exp_ack) $display("FAIL rr_ack k=%0d got %b want %b", k, bus.input_ack, exp_ack); else pass_cnt++;
      step();
      total_cnt++; if (bus.output_stb !== 1'b0) $display("FAIL rr_gap_stb k=%0d got %b want 0", k, bus.output_stb); else pass_cnt++;
      total_cnt++; if (bus.input_ack !== 4'b0000) $display("FAIL rr_gap_ack k=%0d got %b want 0000", k, bus.input_ack); else pass_cnt++;
    end
    bus.input_stb = 4'b0000;
    step();
  endtask

  task automatic test_back_pressure();
    do_reset();
    bus.input_data = {32'h33, 32'hDEADBEEF, 32'h11, 32'h00};
    bus.input_stb  = 4'b0100;
    step();
    total_cnt++; if (bus.input_ack !== 4'b0100) $display("FAIL bp_grant_ack got %b want 0100", bus.input_ack); else pass_cnt++;
    bus.input_stb = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) bus.input_stb = 4'b1011;
      total_cnt++; if (bus.output_stb !== 1'b1) $display("FAIL bp_stb i=%0d got %b want 1", i, bus.output_stb); else pass_cnt++;
      total_cnt++; if (bus.output_data !== 32'hDEADBEEF) $display("FAIL bp_data i=%0d got %h want deadbeef", i, bus.output_data); else pass_cnt++;
      total_cnt++; if (bus.output_channel !== 2'd2) $display("FAIL bp_channel i=%0d got %0d want 2", i, bus.output_channel); else pass_cnt++;
      total_cnt++; if (bus.input_ack !== 4'b0000) $display("FAIL bp_no_ack i=%0d got %b want 0000", i, bus.input_ack); else pass_cnt++;
    end
    bus.output_ack = 1'b1;
    step();
    total_cnt++; if (bus.output_stb !== 1'b0) $display("FAIL bp_release_stb got %b want 0", bus.output_stb); else pass_cnt++;
    step();
    total_cnt++; if (bus.input_ack !== 4'b1000) $display("FAIL bp_next_ack got %b want 1000", bus.input_ack); else pass_cnt++;
    total_cnt++; if (bus.output_data !== 32'h33) $display("FAIL bp_next_data got %h want 33", bus.output_data); else pass_cnt++;
    bus.input_stb = 4'b0000;
    step();
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    bus.output_ack = 1'b1;
    bus.input_stb  = 4'b1000;
    step();
    total_cnt++; if (bus.output_channel !== 2'd3) $display("FAIL sw_first_channel got %0d want 3", bus.output_channel); else pass_cnt++;
    bus.input_stb = 4'b0000;
    step();
    bus.input_stb = 4'b0010;
    step();
    total_cnt++; if (bus.input_ack !== 4'b0010) $display("FAIL sw_wrap_ack got %b want 0010", bus.input_ack); else pass_cnt++;
    total_cnt++; if (bus.output_data !== 32'hA1) $display("FAIL sw_wrap_data got %h want a1", bus.output_data); else pass_cnt++;
    bus.input_stb = 4'b0000;
    step();
    bus.input_stb = 4'b1001;
    step();
    total_cnt++; if (bus.output_channel !== 2'd3) $display("FAIL sw_3_before_0 got %0d want 3", bus.output_channel); else pass_cnt++;
    total_cnt++; if (bus.input_ack !== 4'b1000) $display("FAIL sw_3_ack got %b want 1000", bus.input_ack); else pass_cnt++;
    bus.input_stb = 4'b0001;
    step();
    step();
    total_cnt++; if (bus.output_channel !== 2'd0) $display("FAIL sw_then_0 got %0d want 0", bus.output_channel); else pass_cnt++;
    total_cnt++; if (bus.input_ack !== 4'b0001) $display("FAIL sw_0_ack got %b want 0001", bus.input_ack); else pass_cnt++;
    bus.input_stb = 4'b0000;
    step();
  endtask

  task automatic test_exception();
    do_reset();
    bus.exception_in = 4'b1000;
    total_cnt++; if (bus.exception !== 1'b0) $display("FAIL exc_before_edge got %b want 0", bus.exception); else pass_cnt++;
    step();
    bus.exception_in = 4'b0000;
    total_cnt++; if (bus.exception !== 1'b1) $display("FAIL exc_set got %b want 1", bus.exception); else pass_cnt++;
    for (int i = 0; i < 5; i++) step();
    total_cnt++; if (bus.exception !== 1'b1) $display("FAIL exc_sticky got %b want 1", bus.exception); else pass_cnt++;
    do_reset();
    total_cnt++; if (bus.exception !== 1'b0) $display("FAIL exc_cleared got %b want 0", bus.exception); else pass_cnt++;
  endtask

`ifdef STREAM_HUB_RR_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    bus.input_stb = 4'b0011;
    step();
    total_cnt++; if (bus.output_channel !== 2'd0) $display("FAIL to_grant got %0d want 0", bus.output_channel); else pass_cnt++;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 1) bus.input_stb = 4'b0010;
      total_cnt++; if (bus.output_stb !== 1'b1) $display("FAIL to_hold i=%0d got %b want 1", i, bus.output_stb); else pass_cnt++;
    end
    step();
    total_cnt++; if (bus.output_stb !== 1'b0) $display("FAIL to_drop got %b want 0", bus.output_stb); else pass_cnt++;
    total_cnt++; if (bus.exception !== 1'b1) $display("FAIL to_exception got %b want 1", bus.exception); else pass_cnt++;
    step();
    total_cnt++; if (bus.input_ack !== 4'b0010) $display("FAIL to_next_ack got %b want 0010", bus.input_ack); else pass_cnt++;
    bus.input_stb = 4'b0000;
    bus.output_ack = 1'b1;
    step();
  endtask
`endif

  initial begin
    bus.input_data   = '0;
    bus.input_stb    = '0;
    bus.output_ack   = 1'b0;
    bus.exception_in = '0;
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_sparse_wrap();
    test_exception();
`ifdef STREAM_HUB_RR_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
